// File: rtl/uart_stream.sv
// uart_stream: byte-stream UART with TX and RX FIFOs, 2-flop RX synchroniser,
// mid-bit RX sampling and sticky error flags.
// Optional feature macro: UART_PARITY_EN (even parity bit + rx_parity_err port).

// Power-of-2 FIFO; the extra pointer bit tells full from empty.
module uart_stream_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_depth_check
    $error("uart_stream_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // Pop is ignored when empty; a push into a full FIFO is taken only alongside a pop.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

module uart_stream #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       serial_rx,
  output logic       serial_tx,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  input  logic       clear_err,
  output logic       rx_overrun,
  output logic       rx_frame_err
`ifdef UART_PARITY_EN
  ,
  output logic       rx_parity_err
`endif
);
  localparam int unsigned DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned CW  = $clog2(DIV);
  localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(DIV / 2 - 1);

  if (DIV < 4) begin : g_div_check
    $error("uart_stream: CLK_HZ/BAUD yields a bit divider below 4");
  end

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] TX_PARITY = 3'd3;
`endif
  localparam logic [2:0] TX_STOP   = 3'd4;

  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] RX_PARITY = 3'd3;
`endif
  localparam logic [2:0] RX_STOP   = 3'd4;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd5;

  // ---------------- TX path ----------------
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_head;
  logic [2:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_line_q, tx_line_d;
  logic          tx_cnt_end;
`ifdef UART_PARITY_EN
  logic          tx_par_q, tx_par_d;
`endif

  assign tx_push    = tx_valid && !tx_full;
  assign tx_ready   = !tx_full;
  assign serial_tx  = tx_line_q;
  assign tx_cnt_end = (tx_cnt_q == BIT_LAST);

  uart_stream_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (tx_push),
    .wdata   (tx_data),
    .pop     (tx_pop),
    .rdata   (tx_head),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  // TX frame sequencer; the line register changes on the same edge as the state.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    if (tx_state_q != TX_IDLE) begin
      tx_cnt_d = tx_cnt_end ? '0 : tx_cnt_q + 1'b1;
    end
    case (tx_state_q)
      TX_IDLE: begin
        tx_line_d = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
`ifdef UART_PARITY_EN
          tx_par_d   = ^tx_head;
`endif
          tx_line_d  = 1'b0;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_end) begin
          tx_line_d  = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt_end) begin
          if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            tx_line_d  = tx_par_q;
            tx_state_d = TX_PARITY;
`else
            tx_line_d  = 1'b1;
            tx_state_d = TX_STOP;
`endif
          end else begin
            tx_line_d  = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (tx_cnt_end) begin
          tx_line_d  = 1'b1;
          tx_state_d = TX_STOP;
        end
      end
`endif
      TX_STOP: begin
        if (tx_cnt_end) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
`ifdef UART_PARITY_EN
            tx_par_d   = ^tx_head;
`endif
            tx_line_d  = 1'b0;
            tx_state_d = TX_START;
          end else begin
            tx_line_d  = 1'b1;
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: begin
        tx_line_d  = 1'b1;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  // TX state registers; reset drives the line high immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  // ---------------- RX path ----------------
  logic [1:0]    sync_q, sync_d;
  logic          rx_prev_q, rx_prev_d;
  logic          rx_s, rx_fall;
  logic [2:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_cnt_end;
  logic          rx_push, rx_full, rx_empty;
  logic [7:0]    rx_head;
  logic          frame_set, overrun_set;
  logic          rx_overrun_q, rx_overrun_d;
  logic          rx_frame_err_q, rx_frame_err_d;
`ifdef UART_PARITY_EN
  logic          parity_set;
  logic          rx_parity_err_q, rx_parity_err_d;
`endif

  assign rx_s       = sync_q[1];
  assign rx_fall    = rx_prev_q && !rx_s;
  assign rx_cnt_end = (rx_cnt_q == BIT_LAST);
  assign rx_valid   = !rx_empty;
  assign rx_data    = rx_empty ? '0 : rx_head;
  assign overrun_set = rx_push && rx_full && !rx_ready;
  assign rx_overrun   = rx_overrun_q;
  assign rx_frame_err = rx_frame_err_q;
`ifdef UART_PARITY_EN
  assign rx_parity_err = rx_parity_err_q;
`endif

  uart_stream_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rx_push),
    .wdata   (rx_shift_q),
    .pop     (rx_ready),
    .rdata   (rx_head),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  // RX frame sequencer: start qualified at half a bit, then samples every DIV cycles.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    frame_set  = 1'b0;
`ifdef UART_PARITY_EN
    parity_set = 1'b0;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) begin
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == BIT_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_cnt_end) begin
          rx_cnt_d   = '0;
          parity_set = (rx_s != ^rx_shift_q);
          rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
`endif
      RX_STOP: begin
        if (rx_cnt_end) begin
          rx_cnt_d = '0;
          if (rx_s) begin
            rx_push    = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            frame_set  = 1'b1;
            rx_state_d = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        rx_cnt_d = '0;
        if (rx_s) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // Synchroniser shift and sticky flags; a set event wins over clear_err.
  always_comb begin
    sync_d    = {sync_q[0], serial_rx};
    rx_prev_d = rx_s;
    rx_overrun_d   = clear_err ? 1'b0 : rx_overrun_q;
    rx_frame_err_d = clear_err ? 1'b0 : rx_frame_err_q;
    if (overrun_set) rx_overrun_d = 1'b1;
    if (frame_set)   rx_frame_err_d = 1'b1;
`ifdef UART_PARITY_EN
    rx_parity_err_d = clear_err ? 1'b0 : rx_parity_err_q;
    if (parity_set) rx_parity_err_d = 1'b1;
`endif
  end

  // RX state, synchroniser and flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q         <= '1;
      rx_prev_q      <= 1'b1;
      rx_state_q     <= RX_IDLE;
      rx_cnt_q       <= '0;
      rx_bit_q       <= '0;
      rx_shift_q     <= '0;
      rx_overrun_q   <= 1'b0;
      rx_frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
      rx_parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q         <= sync_d;
      rx_prev_q      <= rx_prev_d;
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_bit_q       <= rx_bit_d;
      rx_shift_q     <= rx_shift_d;
      rx_overrun_q   <= rx_overrun_d;
      rx_frame_err_q <= rx_frame_err_d;
`ifdef UART_PARITY_EN
      rx_parity_err_q <= rx_parity_err_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_stream.sv
// Scoreboard bench for uart_stream (DIV=10, depth 4). Honours UART_PARITY_EN.
module tb_uart_stream;
  localparam int unsigned CLK_HZ = 1000000;
  localparam int unsigned BAUD   = 100000;
  localparam int unsigned DIV    = 10;
  localparam int unsigned DEPTH  = 4;
`ifdef UART_PARITY_EN
  localparam int unsigned SLOTS  = 11;
`else
  localparam int unsigned SLOTS  = 10;
`endif
  localparam int unsigned FRAME  = SLOTS * DIV;

  logic       clk;
  logic       reset_n;
  logic       serial_rx;
  logic       serial_tx;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       clear_err;
  logic       rx_overrun;
  logic       rx_frame_err;
`ifdef UART_PARITY_EN
  logic       rx_parity_err;
  logic       rx_par_flip;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rx_valid_cnt = 0;
  logic [7:0] tx_exp_q [$];
  logic [7:0] rx_exp_q [$];
  int         tx_starts [$];

  uart_stream #(
    .CLK_HZ   (CLK_HZ),
    .BAUD     (BAUD),
    .TX_DEPTH (DEPTH),
    .RX_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .serial_rx    (serial_rx),
    .serial_tx    (serial_tx),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .clear_err    (clear_err),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
`ifdef UART_PARITY_EN
    ,
    .rx_parity_err (rx_parity_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got cycle %0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Drive one frame onto serial_rx, starting and ending on a falling clock edge.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    serial_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    serial_rx = (^b) ^ rx_par_flip;
    repeat (DIV) @(negedge clk);
`endif
    serial_rx = stop;
    repeat (DIV) @(negedge clk);
    serial_rx = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_serial_tx"}, 32'(serial_tx), 32'h1);
    check({tag, "_tx_ready"}, 32'(tx_ready), 32'h1);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
    check({tag, "_rx_data"}, 32'(rx_data), 32'h0);
    check({tag, "_rx_overrun"}, 32'(rx_overrun), 32'h0);
    check({tag, "_rx_frame_err"}, 32'(rx_frame_err), 32'h0);
`ifdef UART_PARITY_EN
    check({tag, "_rx_parity_err"}, 32'(rx_parity_err), 32'h0);
`endif
  endtask

  // RX monitor: every accepted byte is compared against the scoreboard head.
  always @(negedge clk) begin
    if (reset_n && rx_valid) rx_valid_cnt++;
    if (reset_n && rx_valid && rx_ready) begin
      if (rx_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected: got byte 0x%0h required none", rx_data);
      end else begin
        check("rx_byte", 32'(rx_data), 32'(rx_exp_q.pop_front()));
      end
    end
  end

  // TX monitor: captures every sample of a frame, checks bit stability, stop and parity.
  initial begin : tx_monitor
    logic       last;
    logic       aborted;
    logic       stable;
    logic       par_ok;
    logic [7:0] byte_v;
    logic [2:0] shape;
    logic       samp [FRAME];
    last = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        last = 1'b1;
      end else if (last && !serial_tx) begin
        tx_starts.push_back(cyc);
        aborted = 1'b0;
        samp[0] = serial_tx;
        for (int j = 1; j < int'(FRAME); j++) begin
          @(negedge clk);
          if (!reset_n) aborted = 1'b1;
          samp[j] = serial_tx;
        end
        if (!aborted) begin
          stable = 1'b1;
          for (int s = 0; s < int'(SLOTS); s++)
            for (int k = 1; k < int'(DIV); k++)
              if (samp[s*DIV+k] !== samp[s*DIV]) stable = 1'b0;
          for (int b = 0; b < 8; b++) byte_v[b] = samp[(b+1)*DIV];
          par_ok = 1'b1;
`ifdef UART_PARITY_EN
          par_ok = (samp[9*DIV] == ^byte_v);
`endif
          shape = {stable, samp[(SLOTS-1)*DIV], par_ok};
          if (tx_exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx_unexpected: got frame 0x%0h required none", byte_v);
          end else begin
            check("tx_frame_data", 32'(byte_v), 32'(tx_exp_q.pop_front()));
            check("tx_frame_shape", 32'(shape), 32'h7);
          end
        end
        last = samp[FRAME-1];
      end else begin
        last = serial_tx;
      end
    end
  end

  initial begin : stimulus
    logic [7:0] b2b [5];
    logic [7:0] ovr [5];
    b2b = '{8'h01, 8'h80, 8'hFF, 8'h3C, 8'hC3};
    ovr = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99};
    reset_n = 1'b1; serial_rx = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    rx_ready = 1'b0; clear_err = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_flip = 1'b0;
`endif
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte into an idle transmitter: line falls on the second edge.
    tx_valid = 1'b1; tx_data = 8'hA5; tx_exp_q.push_back(8'hA5);
    @(negedge clk);
    tx_valid = 1'b0; tx_data = 8'h00;
    check("tx_high_after_edge1", 32'(serial_tx), 32'h1);
    @(negedge clk);
    check("tx_low_at_edge2", 32'(serial_tx), 32'h0);
    repeat (FRAME + 20) @(negedge clk);

    // Five back-to-back writes: one in flight, four queued, then full.
    tx_starts.delete();
    for (int i = 0; i < 5; i++) begin
      tx_valid = 1'b1; tx_data = b2b[i]; tx_exp_q.push_back(b2b[i]);
      check("tx_ready_before_accept", 32'(tx_ready), 32'h1);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("tx_ready_full", 32'(tx_ready), 32'h0);
    repeat (5 * FRAME + 30) @(negedge clk);
    check("tx_frame_count", 32'(tx_starts.size()), 32'd5);
    if (tx_starts.size() == 5)
      for (int k = 1; k < 5; k++)
        check("tx_gapless", 32'(tx_starts[k] - tx_starts[k-1]), 32'(FRAME));

    // Clean receive with rx_ready high.
    rx_ready = 1'b1;
    rx_valid_cnt = 0;
    rx_exp_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    repeat (5) @(negedge clk);
    check("rx_valid_pulse_len", 32'(rx_valid_cnt), 32'd1);
    check("rx_flags_clean", 32'({rx_overrun, rx_frame_err}), 32'h0);

    // Short low glitch is rejected, next frame still lands.
    rx_valid_cnt = 0;
    serial_rx = 1'b0;
    repeat (3) @(negedge clk);
    serial_rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_no_byte", 32'(rx_valid_cnt), 32'd0);
    check("glitch_no_flags", 32'({rx_overrun, rx_frame_err}), 32'h0);
    rx_exp_q.push_back(8'h55);
    send_rx(8'h55, 1'b1);
    repeat (5) @(negedge clk);

    // Framing error: byte discarded, flag sticky until clear_err.
    rx_valid_cnt = 0;
    send_rx(8'h12, 1'b0);
    repeat (5) @(negedge clk);
    check("frame_err_set", 32'(rx_frame_err), 32'h1);
    check("frame_err_no_byte", 32'(rx_valid_cnt), 32'd0);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("frame_err_cleared", 32'(rx_frame_err), 32'h0);

    // Overrun: four retained in order, fifth dropped.
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_rx(ovr[i], 1'b1);
      if (i == 3) check("overrun_not_yet", 32'(rx_overrun), 32'h0);
    end
    repeat (3) @(negedge clk);
    check("overrun_set", 32'(rx_overrun), 32'h1);
    check("overrun_head", 32'(rx_data), 32'h11);
    for (int i = 0; i < 4; i++) rx_exp_q.push_back(ovr[i]);
    rx_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("overrun_drained", 32'(rx_exp_q.size()), 32'd0);
    check("overrun_fifo_empty", 32'(rx_valid), 32'h0);

`ifdef UART_PARITY_EN
    // Bad parity: flag set, byte still delivered.
    rx_par_flip = 1'b1;
    rx_exp_q.push_back(8'h5A);
    send_rx(8'h5A, 1'b1);
    rx_par_flip = 1'b0;
    repeat (3) @(negedge clk);
    check("parity_err_set", 32'(rx_parity_err), 32'h1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("parity_err_cleared", 32'(rx_parity_err), 32'h0);
`endif

    // Reset mid-frame with TX in its start bit and RX holding a byte.
    rx_ready = 1'b0;
    send_rx(8'h77, 1'b1);
    repeat (3) @(negedge clk);
    check("pre_reset_rx_valid", 32'(rx_valid), 32'h1);
    check("pre_reset_rx_data", 32'(rx_data), 32'h77);
    fork
      send_rx(8'h66, 1'b1);
      begin
        repeat (30) @(negedge clk);
        tx_valid = 1'b1; tx_data = 8'h5A;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_tx_start", 32'(serial_tx), 32'h0);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_reset");
      end
    join
    serial_rx = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("held_reset");
    reset_n = 1'b1;
    rx_ready = 1'b1;
    repeat (30) @(negedge clk);
    check("post_reset_rx_idle", 32'(rx_valid), 32'h0);
    check("post_reset_tx_idle", 32'(serial_tx), 32'h1);

    check("tx_scoreboard_empty", 32'(tx_exp_q.size()), 32'd0);
    check("rx_scoreboard_empty", 32'(rx_exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
